// File: rtl/morra_match_sequencer.sv
// Morra match sequencer: collects one move per player, configures and drives the morra core,
// samples round/match results and keeps saturating score counters. Optional: MORRA_COLLECT_TIMEOUT_EN.
`timescale 1ns/1ps
module morra_match_sequencer #(
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned RES_LAT     = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             START,
  input  logic [3:0]       CFG_MAX,
  input  logic [1:0]       P1_MOVE,
  input  logic             P1_VALID,
  output logic             P1_READY,
  input  logic [1:0]       P2_MOVE,
  input  logic             P2_VALID,
  output logic             P2_READY,
  output logic [1:0]       CORE_PRIMO,
  output logic [1:0]       CORE_SECONDO,
  output logic             CORE_INIZIA,
  input  logic [1:0]       CORE_MANCHE,
  input  logic [1:0]       CORE_PARTITA,
  output logic [CNT_W-1:0] ROUNDS,
  output logic [CNT_W-1:0] INVALIDS,
  output logic [CNT_W-1:0] WINS_P1,
  output logic [CNT_W-1:0] WINS_P2,
  output logic [1:0]       RESULT,
  output logic             BUSY,
  output logic             DONE
);

  if (CNT_W < 1 || RES_LAT < 1 || RES_LAT > 7 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("morra_match_sequencer: illegal parameter value");
  end

  localparam logic [2:0] ResLat = 3'(RES_LAT);

  typedef enum logic [2:0] {StIdle, StCfg, StCollect, StIssue, StWait, StFin} state_e;

  state_e           state_q;
  logic             p1_held_q, p2_held_q;
  logic [1:0]       p1_move_q, p2_move_q;
  logic [2:0]       lat_q;
  logic [1:0]       primo_q, secondo_q;
  logic             inizia_q, done_q;
  logic [1:0]       result_q;
  logic [CNT_W-1:0] rounds_q, invalids_q, wins1_q, wins2_q;

  logic       collect;
  logic       p1_rdy, p2_rdy, p1_take, p2_take, p1_have, p2_have;
  logic [1:0] p1_next_move, p2_next_move;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    collect      = (state_q == StCollect);
    p1_rdy       = collect & ~p1_held_q;
    p2_rdy       = collect & ~p2_held_q;
    p1_take      = P1_VALID & p1_rdy;
    p2_take      = P2_VALID & p2_rdy;
    p1_have      = p1_held_q | p1_take;
    p2_have      = p2_held_q | p2_take;
    p1_next_move = p1_held_q ? p1_move_q : P1_MOVE;
    p2_next_move = p2_held_q ? p2_move_q : P2_MOVE;
  end

`ifdef MORRA_COLLECT_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q;
  logic            tmo_hit;
  // Any capture on the expiry edge wins; the check repeats each cycle until resolved.
  assign tmo_hit = collect & ~p1_take & ~p2_take & (tmo_q >= TmoW'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      p1_held_q  <= 1'b0;
      p2_held_q  <= 1'b0;
      p1_move_q  <= 2'b00;
      p2_move_q  <= 2'b00;
      lat_q      <= 3'd0;
      primo_q    <= 2'b00;
      secondo_q  <= 2'b00;
      inizia_q   <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 2'b00;
      rounds_q   <= '0;
      invalids_q <= '0;
      wins1_q    <= '0;
      wins2_q    <= '0;
`ifdef MORRA_COLLECT_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (START) begin
            state_q    <= StCfg;
            inizia_q   <= 1'b1;
            primo_q    <= CFG_MAX[3:2];
            secondo_q  <= CFG_MAX[1:0];
            result_q   <= 2'b00;
            rounds_q   <= '0;
            invalids_q <= '0;
            wins1_q    <= '0;
            wins2_q    <= '0;
          end
        end
        StCfg: begin
          state_q   <= StCollect;
          inizia_q  <= 1'b0;
          primo_q   <= 2'b00;
          secondo_q <= 2'b00;
          p1_held_q <= 1'b0;
          p2_held_q <= 1'b0;
`ifdef MORRA_COLLECT_TIMEOUT_EN
          tmo_q     <= '0;
`endif
        end
        StCollect: begin
          if (p1_take) begin
            p1_held_q <= 1'b1;
            p1_move_q <= P1_MOVE;
          end
          if (p2_take) begin
            p2_held_q <= 1'b1;
            p2_move_q <= P2_MOVE;
          end
          if (p1_have && p2_have) begin
            state_q   <= StIssue;
            primo_q   <= p1_next_move;
            secondo_q <= p2_next_move;
            lat_q     <= 3'd1;
          end
`ifdef MORRA_COLLECT_TIMEOUT_EN
          else if (tmo_hit) begin
            // Sole held player wins by forfeit; nobody held gives 11.
            state_q  <= StFin;
            done_q   <= 1'b1;
            result_q <= {p2_held_q | ~p1_held_q, p1_held_q | ~p2_held_q};
          end
          if (!(&tmo_q)) begin
            tmo_q <= tmo_q + TmoW'(1);
          end
`endif
        end
        StIssue, StWait: begin
          if (lat_q == ResLat) begin
            p1_held_q <= 1'b0;
            p2_held_q <= 1'b0;
            case (CORE_MANCHE)
              2'b00: invalids_q <= sat_inc(invalids_q);
              2'b01: begin
                rounds_q <= sat_inc(rounds_q);
                wins1_q  <= sat_inc(wins1_q);
              end
              2'b10: begin
                rounds_q <= sat_inc(rounds_q);
                wins2_q  <= sat_inc(wins2_q);
              end
              default: rounds_q <= sat_inc(rounds_q);
            endcase
            if (CORE_PARTITA != 2'b00) begin
              state_q  <= StFin;
              done_q   <= 1'b1;
              result_q <= CORE_PARTITA;
            end else begin
              state_q   <= StCollect;
              primo_q   <= 2'b00;
              secondo_q <= 2'b00;
`ifdef MORRA_COLLECT_TIMEOUT_EN
              tmo_q     <= '0;
`endif
            end
          end else begin
            lat_q   <= lat_q + 3'd1;
            state_q <= StWait;
          end
        end
        StFin: begin
          state_q   <= StIdle;
          primo_q   <= 2'b00;
          secondo_q <= 2'b00;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign P1_READY     = p1_rdy;
  assign P2_READY     = p2_rdy;
  assign CORE_PRIMO   = primo_q;
  assign CORE_SECONDO = secondo_q;
  assign CORE_INIZIA  = inizia_q;
  assign ROUNDS       = rounds_q;
  assign INVALIDS     = invalids_q;
  assign WINS_P1      = wins1_q;
  assign WINS_P2      = wins2_q;
  assign RESULT       = result_q;
  assign BUSY         = (state_q != StIdle);
  assign DONE         = done_q;

endmodule

// File: tb/tb_morra_match_sequencer.sv
// Bench for morra_match_sequencer: directed round table, reset/timeout sequences and randomized
// matches scored by a round-level model of the counting rules.
`timescale 1ns/1ps
module tb_morra_match_sequencer;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned RES_LAT = 2;
  localparam int unsigned TMO     = 8;
  localparam int          CntMax  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, START, P1_VALID, P2_VALID;
  logic [3:0]       CFG_MAX;
  logic [1:0]       P1_MOVE, P2_MOVE, CORE_MANCHE, CORE_PARTITA;
  logic             P1_READY, P2_READY, CORE_INIZIA, BUSY, DONE;
  logic [1:0]       CORE_PRIMO, CORE_SECONDO, RESULT;
  logic [CNT_W-1:0] ROUNDS, INVALIDS, WINS_P1, WINS_P2;

  int n_checks = 0;
  int n_fail   = 0;
  int m_rnd, m_inv, m_w1, m_w2;

  morra_match_sequencer #(.CNT_W(CNT_W), .RES_LAT(RES_LAT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .START(START), .CFG_MAX(CFG_MAX),
    .P1_MOVE(P1_MOVE), .P1_VALID(P1_VALID), .P1_READY(P1_READY),
    .P2_MOVE(P2_MOVE), .P2_VALID(P2_VALID), .P2_READY(P2_READY),
    .CORE_PRIMO(CORE_PRIMO), .CORE_SECONDO(CORE_SECONDO), .CORE_INIZIA(CORE_INIZIA),
    .CORE_MANCHE(CORE_MANCHE), .CORE_PARTITA(CORE_PARTITA),
    .ROUNDS(ROUNDS), .INVALIDS(INVALIDS), .WINS_P1(WINS_P1), .WINS_P2(WINS_P2),
    .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] m1, m2;
    int         d1, d2;
    logic [1:0] man, par;
    int         e_rnd, e_inv, e_w1, e_w2;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > CntMax) ? CntMax : x;
  endfunction

  task automatic model_round(input logic [1:0] man);
    if (man == 2'b00) m_inv++;
    else begin
      m_rnd++;
      if (man == 2'b01) m_w1++;
      if (man == 2'b10) m_w2++;
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_rounds"}, 32'(ROUNDS), sat(m_rnd));
    chk({tag, "_invalids"}, 32'(INVALIDS), sat(m_inv));
    chk({tag, "_wins_p1"}, 32'(WINS_P1), sat(m_w1));
    chk({tag, "_wins_p2"}, 32'(WINS_P2), sat(m_w2));
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_core"}, {CORE_INIZIA, CORE_PRIMO, CORE_SECONDO}, 0);
    chk({tag, "_ready"}, {P1_READY, P2_READY}, 0);
    chk({tag, "_counters"}, {ROUNDS, INVALIDS, WINS_P1, WINS_P2}, 0);
    chk({tag, "_result"}, RESULT, 0);
  endtask

  // Called at posedge+1 while idle; returns at posedge+1 in the first COLLECT cycle.
  task automatic start_match(input logic [3:0] cfg);
    START = 1'b1;
    CFG_MAX = cfg;
    @(posedge clk); #1;
    START = 1'b0;
    CFG_MAX = 4'($urandom);
    chk("cfg_inizia", CORE_INIZIA, 1);
    chk("cfg_primo", CORE_PRIMO, cfg[3:2]);
    chk("cfg_secondo", CORE_SECONDO, cfg[1:0]);
    chk("cfg_busy", BUSY, 1);
    chk("cfg_counters", {ROUNDS, INVALIDS, WINS_P1, WINS_P2}, 0);
    chk("cfg_result", RESULT, 0);
    @(posedge clk); #1;
    chk("collect_inizia", CORE_INIZIA, 0);
    m_rnd = 0; m_inv = 0; m_w1 = 0; m_w2 = 0;
  endtask

  // One round from COLLECT: players raise VALID after d1/d2 cycles, the core answers man/par.
  task automatic do_round(input logic [1:0] m1, input logic [1:0] m2, input int d1,
                          input int d2, input logic [1:0] man, input logic [1:0] par);
    bit g1, g2;
    int cyc;
    g1 = 0; g2 = 0; cyc = 0;
    CORE_MANCHE = man;
    CORE_PARTITA = par;
    while (!(g1 && g2) && cyc < 50) begin
      P1_MOVE  = m1;
      P2_MOVE  = m2;
      P1_VALID = !g1 && (cyc >= d1);
      P2_VALID = !g2 && (cyc >= d2);
      START    = 1'($urandom);
      CFG_MAX  = 4'($urandom);
      @(negedge clk);
      chk("p1_ready", P1_READY, !g1);
      chk("p2_ready", P2_READY, !g2);
      chk("collect_busy", BUSY, 1);
      chk("collect_inizia", CORE_INIZIA, 0);
      if (P1_VALID && P1_READY) g1 = 1;
      if (P2_VALID && P2_READY) g2 = 1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!(g1 && g2)) chk("capture_bound", 0, 1);
    P1_VALID = 1'b0;
    P2_VALID = 1'b0;
    START = 1'b0;
    for (int k = 0; k < int'(RES_LAT); k++) begin
      chk("issue_primo", CORE_PRIMO, m1);
      chk("issue_secondo", CORE_SECONDO, m2);
      chk("issue_inizia", CORE_INIZIA, 0);
      chk("issue_ready", {P1_READY, P2_READY}, 0);
      chk("issue_done", DONE, 0);
      @(posedge clk); #1;
    end
    if (par != 2'b00) begin
      chk("fin_done", DONE, 1);
      chk("fin_result", RESULT, par);
      chk("fin_busy", BUSY, 1);
      @(posedge clk); #1;
      chk("idle_done", DONE, 0);
      chk("idle_busy", BUSY, 0);
      chk("idle_core", {CORE_INIZIA, CORE_PRIMO, CORE_SECONDO}, 0);
    end else begin
      chk("next_ready", {P1_READY, P2_READY}, 2'b11);
    end
  endtask

  initial begin
    logic [1:0] man, par;
    int nr, cyc;

    vecs[0] = '{2'b01, 2'b11, 0, 3, 2'b01, 2'b00, 1, 0, 1, 0};
    vecs[1] = '{2'b10, 2'b10, 2, 2, 2'b00, 2'b00, 1, 1, 1, 0};
    vecs[2] = '{2'b00, 2'b01, 1, 0, 2'b10, 2'b00, 2, 1, 1, 1};
    vecs[3] = '{2'b11, 2'b01, 0, 0, 2'b11, 2'b00, 3, 1, 1, 1};
    vecs[4] = '{2'b11, 2'b10, 4, 1, 2'b10, 2'b10, 4, 1, 1, 2};

    rst_n = 1'b0; START = 1'b0; CFG_MAX = 4'b0; P1_MOVE = 2'b0; P2_MOVE = 2'b0;
    P1_VALID = 1'b0; P2_VALID = 1'b0; CORE_MANCHE = 2'b0; CORE_PARTITA = 2'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_busy", BUSY, 0);

    // Directed match from the table.
    start_match(4'b0110);
    for (int i = 0; i < 5; i++) begin
      do_round(vecs[i].m1, vecs[i].m2, vecs[i].d1, vecs[i].d2, vecs[i].man, vecs[i].par);
      chk("tbl_rounds", 32'(ROUNDS), vecs[i].e_rnd);
      chk("tbl_invalids", 32'(INVALIDS), vecs[i].e_inv);
      chk("tbl_wins_p1", 32'(WINS_P1), vecs[i].e_w1);
      chk("tbl_wins_p2", 32'(WINS_P2), vecs[i].e_w2);
    end
    @(posedge clk); #1;
    chk("held_rounds", 32'(ROUNDS), 4);
    chk("held_result", RESULT, 2'b10);

    // Reset with nonzero counters.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_idle_zero("reset_nonzero");

    // Reset while waiting on the core result.
    start_match(4'b1001);
    CORE_MANCHE = 2'b01; CORE_PARTITA = 2'b01;
    P1_MOVE = 2'b10; P2_MOVE = 2'b01; P1_VALID = 1'b1; P2_VALID = 1'b1;
    @(posedge clk); #1;
    P1_VALID = 1'b0; P2_VALID = 1'b0;
    @(posedge clk); #1;
    chk("wait_primo", CORE_PRIMO, 2'b10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_idle_zero("reset_wait");
    @(posedge clk); #1;
    chk("reset_wait_no_done", DONE, 0);
    chk("reset_wait_idle", BUSY, 0);

    // Randomized matches against the score model.
    for (int mt = 0; mt < 6; mt++) begin
      start_match(4'($urandom));
      nr = $urandom_range(1, 8);
      par = 2'b00;
      for (int r = 0; r < nr; r++) begin
        man = 2'($urandom_range(0, 3));
        par = (r == nr - 1) ? 2'($urandom_range(1, 3)) : 2'b00;
        model_round(man);
        do_round(2'($urandom), 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 man, par);
        chk_cnt("rnd");
      end
      chk("rnd_result", RESULT, par);
    end

    // Counter saturation.
    start_match(4'b1111);
    for (int r = 0; r < 33; r++) begin
      model_round(2'b01);
      do_round(2'b01, 2'b10, 0, 0, 2'b01, 2'b00);
    end
    model_round(2'b00);
    do_round(2'b11, 2'b11, 0, 0, 2'b00, 2'b01);
    chk_cnt("sat");
    chk("sat_result", RESULT, 2'b01);

`ifdef MORRA_COLLECT_TIMEOUT_EN
    // P1 held, P2 silent: P1 wins by forfeit after TMO collect cycles.
    start_match(4'b0101);
    P1_MOVE = 2'b01; P1_VALID = 1'b1;
    @(posedge clk); #1;
    P1_VALID = 1'b0;
    cyc = 1;
    while (!DONE && cyc < 40) begin
      chk("tmo_inizia", CORE_INIZIA, 0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("tmo_cycles", cyc, TMO);
    chk("tmo_done", DONE, 1);
    chk("tmo_result", RESULT, 2'b01);
    chk("tmo_rounds", 32'(ROUNDS), 0);
    @(posedge clk); #1;
    chk("tmo_idle", {BUSY, DONE, CORE_INIZIA}, 0);

    // Nobody moves: draw by timeout.
    start_match(4'b0101);
    cyc = 0;
    while (!DONE && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("tmo2_cycles", cyc, TMO);
    chk("tmo2_result", RESULT, 2'b11);
    @(posedge clk); #1;
    chk("tmo2_idle", BUSY, 0);
`else
    cyc = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morra_match_sequencer.md
Name: morra_match_sequencer

Overview:
- Front-end controller for the morra cinese game core: collects one move per player through independent valid/ready handshakes, configures the core at match start, issues each round and samples the round/match result.
- Keeps per-match scoreboard counters and presents a one-cycle match-done pulse.
- Sits between the two player input channels and the core's PRIMO/SECONDO/INIZIA inputs and MANCHE/PARTITA outputs.

Parameters:
- CNT_W, 5, width of round, invalid and win counters.
- RES_LAT, 1, cycles between the core inputs being driven and the result being sampled (1..7).
- TIMEOUT_CYC, 255, cycles allowed in COLLECT before a forfeit (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- START  in  1  begin a match; honoured only in IDLE.
- CFG_MAX  in  4  match-length config {primo[1:0], secondo[1:0]}, sent to the core at INIZIA.
- P1_MOVE  in  2  player 1 move (00 = no move, 01/10/11 = hands).
- P1_VALID  in  1  player 1 move valid.
- P1_READY  out  1  sequencer accepts a player 1 move.
- P2_MOVE, P2_VALID, P2_READY  same as P1 for player 2.
- CORE_PRIMO  out  2  to core PRIMO.
- CORE_SECONDO  out  2  to core SECONDO.
- CORE_INIZIA  out  1  to core INIZIA.
- CORE_MANCHE  in  2  core round result (00 invalid, 01 P1, 10 P2, 11 draw).
- CORE_PARTITA  in  2  core match result (00 ongoing, else final).
- ROUNDS  out  CNT_W  valid rounds played.
- INVALIDS  out  CNT_W  rounds rejected by the core (MANCHE = 00).
- WINS_P1, WINS_P2  out  CNT_W  rounds won by each player.
- RESULT  out  2  latched final PARTITA.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when the match ends.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state IDLE.
  - All counters, RESULT, CORE_* and DONE go to 0; READYs go to 0.
  - Reset mid-match aborts without driving INIZIA.
- States:
  - IDLE: START = 1 -> CFG; counters cleared on the same edge.
  - CFG: exactly one cycle; CORE_INIZIA = 1, CORE_PRIMO = CFG_MAX[3:2], CORE_SECONDO = CFG_MAX[1:0] -> COLLECT.
  - COLLECT:
    - P1_READY = ~p1_held and P2_READY = ~p2_held.
    - A move is captured on an edge where VALID & READY. The two players are independent and may both be captured on the same edge.
    - Once both are held -> ISSUE; ISSUE is entered the edge after the second capture.
  - ISSUE/WAIT:
    - CORE_PRIMO/SECONDO are driven with the held moves and CORE_INIZIA = 0.
    - The moves are held for RES_LAT cycles. On the last cycle, CORE_MANCHE/PARTITA are sampled and the held flags are cleared.
  - Result update:
    - MANCHE 00: INVALIDS += 1.
    - MANCHE 01: ROUNDS += 1, WINS_P1 += 1.
    - MANCHE 10: ROUNDS += 1, WINS_P2 += 1.
    - MANCHE 11: ROUNDS += 1.
    - If PARTITA != 00: RESULT <= PARTITA -> FIN; else -> COLLECT.
  - FIN: DONE = 1 for one cycle -> IDLE. RESULT and counters hold until the next START.
- Move values are forwarded unchanged, including 00; validity is judged only by the core.
- Outside COLLECT, READYs are 0. In CFG, ISSUE, WAIT and FIN, CORE_* keep their defined values. In IDLE, CORE_* = 0.
- Counters saturate at all-ones and do not wrap.
- START outside IDLE is ignored.

Optional Feature:
- Macro MORRA_COLLECT_TIMEOUT_EN.
- Defined:
  - A COLLECT cycle counter clears on entry to COLLECT and increments each COLLECT cycle.
  - When it reaches TIMEOUT_CYC with exactly one player held, that player wins by forfeit: RESULT = 01 (P1 held) or 10 (P2 held) -> FIN, with no core issue.
  - With neither player held: RESULT = 11 -> FIN.
  - A capture on the timeout edge takes priority over the timeout.
- Undefined: COLLECT waits indefinitely, and TIMEOUT_CYC is unused.

Test Plan:
- Reset with counters nonzero -> all outputs 0, state IDLE; START with CFG_MAX = 4'b0110 -> one cycle of CORE_INIZIA = 1, CORE_PRIMO = 01, CORE_SECONDO = 10, BUSY = 1.
- P1 valid with 01 at cycle t, P2 valid with 11 at t+3 -> P1_READY drops after t, CORE_PRIMO = 01 and CORE_SECONDO = 11 from t+4; core MANCHE = 01 -> WINS_P1 = 1, ROUNDS = 1.
- Core returns MANCHE = 00 -> INVALIDS = 1, ROUNDS unchanged, back to COLLECT with both READYs high.
- Round with PARTITA = 10 -> RESULT = 10, DONE high exactly one cycle, BUSY low next cycle, counters held.
- rst_n low during WAIT -> next cycle in IDLE, CORE_* = 0, no DONE pulse.
- With MORRA_COLLECT_TIMEOUT_EN and TIMEOUT_CYC = 8: P1 held, P2 silent -> RESULT = 01, DONE pulse, CORE_INIZIA never re-asserted.
